// File: rtl/pipelined_memory_pkg.sv
// Memory access modes shared by the CPU load/store stage and the data memory.
// Lane-mask and alignment helpers keep fault and byte-enable rules in one place.
package pipelined_memory_pkg;

  localparam int MEM_MODE_W = 3;

  typedef enum logic [MEM_MODE_W-1:0] {
    MEM_NONE      = 3'd0,
    MEM_BYTE      = 3'd1,
    MEM_HALFWORD  = 3'd2,
    MEM_WORD      = 3'd3,
    MEM_WORDLEFT  = 3'd4,
    MEM_WORDRIGHT = 3'd5
  } mem_mode_e;

  function automatic logic isDefinedMode(input logic [MEM_MODE_W-1:0] mode);
    return mode <= MEM_WORDRIGHT;
  endfunction

  function automatic logic isAligned(input logic [MEM_MODE_W-1:0] mode, input logic [1:0] offset);
    case (mode)
      MEM_WORD:     return offset == 2'd0;
      MEM_HALFWORD: return !offset[0];
      default:      return 1'b1;
    endcase
  endfunction

  // WORDLEFT covers lanes k..0, WORDRIGHT lanes 3..k.
  function automatic logic [3:0] laneMask(input logic [MEM_MODE_W-1:0] mode, input logic [1:0] offset);
    case (mode)
      MEM_BYTE:      return 4'b0001 << offset;
      MEM_HALFWORD:  return 4'b0011 << offset;
      MEM_WORD:      return 4'b1111;
      MEM_WORDLEFT:  return 4'b1111 >> (2'd3 - offset);
      MEM_WORDRIGHT: return 4'b1111 << offset;
      default:       return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_memory_lane_align.sv
// Byte-lane steering: store data/enables toward the RAM word, and load
// extraction plus sign/zero extension from the registered request fields.
module memory_lane_align
  import pipelined_memory_pkg::*;
(
  input  logic [MEM_MODE_W-1:0] st_mode,
  input  logic [1:0]            st_offset,
  input  logic [31:0]           st_data,
  output logic [31:0]           st_word,
  output logic [3:0]            st_be,
  input  logic [MEM_MODE_W-1:0] ld_mode,
  input  logic [1:0]            ld_offset,
  input  logic                  ld_unsigned,
  input  logic [31:0]           ld_word,
  output logic [31:0]           ld_data
);

  logic [4:0]  st_sh, ld_sh;
  logic [31:0] ld_shifted;

  assign st_sh      = {st_offset, 3'b000};
  assign ld_sh      = {ld_offset, 3'b000};
  assign ld_shifted = ld_word >> ld_sh;
  assign st_be      = laneMask(st_mode, st_offset);

  always_comb begin
    st_word = st_data << st_sh;
    if (st_mode == MEM_WORDLEFT) st_word = st_data >> (5'd24 - st_sh);
  end

  // NONE (stores, faults, reset) yields zero so rspData needs no extra gating.
  always_comb begin
    ld_data = '0;
    case (ld_mode)
      MEM_BYTE:      ld_data = ld_unsigned ? {24'b0, ld_shifted[7:0]}
                                           : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      MEM_HALFWORD:  ld_data = ld_unsigned ? {16'b0, ld_shifted[15:0]}
                                           : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      MEM_WORD:      ld_data = ld_word;
      MEM_WORDLEFT:  ld_data = ld_word << (5'd24 - ld_sh);
      MEM_WORDRIGHT: ld_data = ld_shifted;
      default:       ld_data = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_memory.sv
// Byte-addressed little-endian data memory with valid/ready handshake, 1-cycle
// synchronous read, byte-enable stores and an independent registered fetch port.
module pipelined_memory
  import pipelined_memory_pkg::*;
#(
  parameter int    ADDR_WIDTH = 16,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [31:0]           reqAddress,
  input  logic [31:0]           reqData,
  input  logic [MEM_MODE_W-1:0] reqWriteMode,
  input  logic [MEM_MODE_W-1:0] reqReadMode,
  input  logic                  reqUnsigned,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [31:0]           rspData,
  output logic                  rspFault,
  input  logic [31:0]           pcAddress,
  output logic [31:0]           pcDataOutput
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** WA;

  typedef enum logic {IDLE, RESP} state_e;
  state_e state, state_nxt;

  logic                  accept, wr_on, rd_on, fault, wr_en;
  logic [1:0]            offset;
  logic [WA-1:0]         req_word, pc_word;
  logic [31:0]           st_word, rd_word_q;
  logic [3:0]            st_be;
  logic [MEM_MODE_W-1:0] ld_mode_q;
  logic [1:0]            ld_off_q;
  logic                  ld_uns_q;
  logic                  unused_pc;
  logic [31:0]           mem [WORDS];

  assign offset    = reqAddress[1:0];
  assign req_word  = reqAddress[ADDR_WIDTH-1:2];
  assign pc_word   = pcAddress[ADDR_WIDTH-1:2];
  assign unused_pc = ^{pcAddress[31:ADDR_WIDTH], pcAddress[1:0]};

  assign wr_on = reqWriteMode != MEM_NONE;
  assign rd_on = reqReadMode != MEM_NONE;
  assign fault = (wr_on == rd_on) || !isDefinedMode(reqWriteMode) || !isDefinedMode(reqReadMode)
              || (|reqAddress[31:ADDR_WIDTH])
              || !isAligned(reqWriteMode, offset) || !isAligned(reqReadMode, offset);

  assign accept = reqValid && reqReady && !rst;
  assign wr_en  = accept && wr_on && !fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // reqValid stands in for accept here: in both states a valid request is taken
  // whenever the FSM would move on, and this avoids a loop through reqReady.
  always_comb begin
    state_nxt = state;
    reqReady  = 1'b1;
    rspValid  = 1'b0;
    case (state)
      IDLE: if (reqValid) state_nxt = RESP;
      RESP: begin
        rspValid = 1'b1;
        reqReady = rspReady;
        if (rspReady && !reqValid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_mode_q <= MEM_NONE;
      ld_off_q  <= '0;
      ld_uns_q  <= 1'b0;
      rspFault  <= 1'b0;
    end else if (accept) begin
      ld_mode_q <= fault ? MEM_NONE : reqReadMode;
      ld_off_q  <= offset;
      ld_uns_q  <= reqUnsigned;
      rspFault  <= fault;
    end
  end

  memory_lane_align u_align (
    .st_mode    (reqWriteMode),
    .st_offset  (offset),
    .st_data    (reqData),
    .st_word    (st_word),
    .st_be      (st_be),
    .ld_mode    (ld_mode_q),
    .ld_offset  (ld_off_q),
    .ld_unsigned(ld_uns_q),
    .ld_word    (rd_word_q),
    .ld_data    (rspData)
  );

  // Port A: read-first data port, read enabled only on accept so stalls hold data.
  always_ff @(posedge clk) begin
    if (accept) rd_word_q <= mem[req_word];
    for (int i = 0; i < 4; i++)
      if (wr_en && st_be[i]) mem[req_word][8*i +: 8] <= st_word[8*i +: 8];
  end

  // Port B: fetch, free-running and wrapping modulo memory size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcDataOutput <= '0;
    else     pcDataOutput <= mem[pc_word];
  end

endmodule
